// File: rtl/adders_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | adders_pkg : shared types/helpers for the sequential adders      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package adders_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Slice counter width; the extra bit leaves room for a k == NSLICE value.
    function automatic int cnt_width(input int nslice);
        return $clog2(nslice) + 1;
    endfunction

endpackage : adders_pkg
`default_nettype wire

// File: rtl/claa_slice.sv
`default_nettype none
// +------------------------------------------------------------------+
// | claa_slice : CHUNK-bit combinational carry-lookahead adder       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module claa_slice #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             c_i,
    output logic [CHUNK-1:0] s_o,
    output logic             c_o
);

    logic [CHUNK-1:0] w_p;
    logic [CHUNK-1:0] w_g;
    logic [CHUNK:0]   w_c;

    assign w_p = a_i ^ b_i;
    assign w_g = a_i & b_i;

    // Each carry is a flat sum of generate terms gated by propagate prefixes,
    // so no carry depends on a lower computed carry.
    always_comb begin : p_lookahead
        logic v_pp;
        logic v_c;
        w_c    = '0;
        w_c[0] = c_i;
        v_pp   = 1'b0;
        v_c    = 1'b0;
        for (int i = 0; i < CHUNK; i++) begin
            v_c  = w_g[i];
            v_pp = w_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                v_c  = v_c | (v_pp & w_g[j]);
                v_pp = v_pp & w_p[j];
            end
            v_c        = v_c | (v_pp & c_i);
            w_c[i + 1] = v_c;
        end
    end

    assign s_o = w_p ^ w_c[CHUNK-1:0];
    assign c_o = w_c[CHUNK];

endmodule : claa_slice
`default_nettype wire

// File: rtl/claa_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | claa_seq : multi-cycle adder/subtractor, one CHUNK slice / cycle |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module claa_seq
    import adders_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_valid_i,
    output logic             start_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             c_i,
    input  logic             sub_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [WIDTH-1:0] s_o,
    output logic             c_o,
    output logic             ovf_o
);

    localparam int SAFE_CHUNK = (CHUNK >= 1) ? CHUNK : 1;
    localparam int NSLICE     = WIDTH / SAFE_CHUNK;
    localparam int CW         = cnt_width(NSLICE);
    localparam logic [CW-1:0] LAST_K = CW'(NSLICE - 1);

    generate
        if ((CHUNK < 1) || ((WIDTH % SAFE_CHUNK) != 0)) begin : g_bad_params
            $error("claa_seq: WIDTH must be a multiple of CHUNK and CHUNK >= 1");
        end
    endgenerate

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             co_q, co_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] w_a_sl;
    logic [CHUNK-1:0] w_b_sl;
    logic [CHUNK-1:0] w_sum;
    logic             w_cout;

    always_comb begin
        w_a_sl = '0;
        w_b_sl = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (k_q == CW'(i)) begin
                w_a_sl = a_q[i*CHUNK +: CHUNK];
                w_b_sl = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    claa_slice #(
        .CHUNK (CHUNK)
    ) u_slice (
        .a_i (w_a_sl),
        .b_i (w_b_sl),
        .c_i (carry_q),
        .s_o (w_sum),
        .c_o (w_cout)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            k_q     <= k_d;
            s_q     <= s_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        k_d     = k_q;
        s_d     = s_q;
        co_d    = co_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start_valid_i) begin
                    a_d     = a_i;
                    b_d     = sub_i ? ~b_i : b_i;
                    carry_d = sub_i | c_i;
                    k_d     = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                for (int i = 0; i < NSLICE; i++) begin
                    if (k_q == CW'(i)) begin
                        s_d[i*CHUNK +: CHUNK] = w_sum;
                    end
                end
                carry_d = w_cout;
                k_d     = k_q + CW'(1);
                if (k_q == LAST_K) begin
                    state_d = S_DONE;
                    co_d    = w_cout;
                    // The top slice's sum MSB is the result sign bit.
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (w_sum[CHUNK-1] != a_q[WIDTH-1]);
                end
            end
            S_DONE: begin
                if (res_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign start_ready_o = (state_q == S_IDLE);
    assign res_valid_o   = (state_q == S_DONE);
    assign s_o           = s_q;
    assign c_o           = co_q;
    assign ovf_o         = ovf_q;

endmodule : claa_seq
`default_nettype wire
